// File: rtl/width_16to8_buf.sv
// rtl/width_16to8_buf.sv - 16-bit word FIFO re-emitted as bytes, high byte first
// Valid-only word input with drop-on-full and a sticky overflow flag; valid/ready byte output.
module width_16to8_buf #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_in,
  input  logic [15:0]   data_in,
  input  logic          ready_in,
  output logic          valid_out,
  output logic [7:0]    data_out,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow
);

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ph_q, ph_d;
  logic          ovf_q, ovf_d;

  logic          wr;
  logic          drop;
  logic          xfer;
  logic          pop;
  logic [15:0]   head;

  assign full      = (cnt_q == CNT_FULL);
  assign empty     = (cnt_q == '0);
  assign level     = cnt_q;
  assign overflow  = ovf_q;
  assign valid_out = !empty;
  assign head      = mem_q[rp_q];

  // Only registered state feeds the byte output, so it holds until accepted.
  always_comb begin
    data_out = 8'h00;
    if (!empty) begin
      data_out = ph_q ? head[7:0] : head[15:8];
    end
  end

  always_comb begin
    wr    = valid_in && !full;
    drop  = valid_in && full;
    xfer  = valid_out && ready_in;
    pop   = xfer && ph_q;

    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    ph_d  = ph_q;
    ovf_d = ovf_q | drop;

    if (wr) begin
      mem_d[wp_q] = data_in;
      wp_d        = wp_q + PTR_ONE;
    end

    if (xfer) begin
      ph_d = !ph_q;
    end
    if (pop) begin
      rp_d = rp_q + PTR_ONE;
    end

    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ph_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_width_16to8_buf.sv
// tb/tb_width_16to8_buf.sv - scoreboard bench for width_16to8_buf
// Driver queues expected bytes for accepted words; a negedge monitor compares and retires them.
module tb_width_16to8_buf;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [15:0]   data_in = 16'h0000;
  logic          ready_in = 1'b0;
  logic          valid_out;
  logic [7:0]    data_out;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;

  width_16to8_buf #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         pending = 0;
  logic       ovf_cur = 1'b0;
  logic       ovf_nxt = 1'b0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from the stored-word count.
  task automatic cycle(input logic vin, input logic [15:0] din, input logic rdy);
    @(posedge clk);
    #1;
    pending  = 0;
    ovf_cur  = ovf_nxt;
    rst_n    = 1'b1;
    valid_in = vin;
    data_in  = din;
    ready_in = rdy;
    if (vin) begin
      if ((exp_q.size() + 1) / 2 == DEPTH) begin
        ovf_nxt = 1'b1;
      end else begin
        exp_q.push_back(din[15:8]);
        exp_q.push_back(din[7:0]);
        pending = 2;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    pending  = 0;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b0;
    exp_q.delete();
    ovf_nxt  = 1'b0;
    ovf_cur  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      cycle(1'b0, 16'h0000, 1'b1);
      n++;
    end
    cycle(1'b0, 16'h0000, 1'b1);
    chk("drain_left", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      int stored;
      int words;
      stored = exp_q.size() - pending;
      words  = (stored + 1) / 2;
      chk("valid_out", int'(valid_out), int'(stored != 0));
      chk("data_out", int'(data_out), (stored != 0) ? int'(exp_q[0]) : 0);
      chk("level", int'(level), words);
      chk("full", int'(full), int'(words == DEPTH));
      chk("empty", int'(empty), int'(words == 0));
      chk("overflow", int'(overflow), int'(ovf_cur));
      if (stored != 0 && ready_in) begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    do_reset();
    do_reset();

    // single word
    cycle(1'b1, 16'hA55A, 1'b1);
    repeat (4) cycle(1'b0, 16'h0000, 1'b1);

    // stall with output held
    cycle(1'b1, 16'h1234, 1'b0);
    repeat (5) cycle(1'b0, 16'h0000, 1'b0);
    repeat (4) cycle(1'b0, 16'h0000, 1'b1);

    // fill and overflow
    for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(i), 1'b0);
    cycle(1'b0, 16'h0000, 1'b0);
    drain();

    // wrap at one word per two cycles
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 16'h0100 + 16'(i), 1'b1);
      cycle(1'b0, 16'h0000, 1'b1);
    end
    drain();

    // full plus pop in the same cycle
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'h0A00 + 16'(i), 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b1, 16'hBEEF, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    drain();

    // reset in the middle of a word
    do_reset();
    cycle(1'b1, 16'hCAFE, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);
    do_reset();
    cycle(1'b1, 16'h0F0F, 1'b1);
    drain();

    // randomized traffic, including overflow pressure
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 1) == 1), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/width_16to8_buf.md
# width_16to8_buf

Downstream stage for the 8-to-16 packer. Accepts 16-bit words on a valid-only interface (the packer has no backpressure), buffers them in a small FIFO and re-emits them as 8-bit bytes, high byte first, on a valid/ready interface toward the byte-wide sink. Words that arrive while the buffer is full are dropped and flagged with a sticky overflow bit.

## Interface
- DEPTH, 4: FIFO depth in 16-bit words; power of two, ≥2.
- AW, log2(DEPTH): pointer width; derived, not overridden.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- valid_in  input  1  data_in holds a word this cycle; no backpressure.
- data_in  input  16  word; [15:8] is the first byte received upstream.
- ready_in  input  1  sink can take a byte this cycle.
- valid_out  output  1  data_out holds a valid byte.
- data_out  output  8  current byte.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.
- level  output  AW+1  stored words, including a partially sent head word.
- overflow  output  1  sticky; set when a word is dropped.

## Operation
- Storage: DEPTH×16 register array, write pointer wp, read pointer rp (AW bits, wrap modulo DEPTH), counter cnt (AW+1 bits); full/empty/level derived from cnt.
- Write: valid_in && !full at the edge → mem[wp] ← data_in, wp+1.
- Drop: valid_in && full → word discarded, overflow ← 1; overflow stays 1 until reset.
- full is evaluated from the registered cnt. A word arriving while full is dropped even if a pop happens in the same cycle.
- Byte phase register ph (0 = high byte, 1 = low byte).
  - data_out = ph ? mem[rp][7:0] : mem[rp][15:8].
  - valid_out = !empty.
  - data_out is forced to 8'h00 when empty.
- Transfer: valid_out && ready_in.
  - ph=0 → ph ← 1.
  - ph=1 → ph ← 0, rp+1, word popped.
- cnt update: +1 on write only; −1 on pop only; unchanged on write+pop in the same cycle.
- valid_out and data_out are driven from registers only; there is no combinational path from valid_in, data_in or ready_in.
- Once valid_out is asserted, valid_out and data_out hold stable until the transfer occurs.
- Reset (rst_n=0 at an edge): wp=rp=0, cnt=0, ph=0, overflow=0.
  - Array contents are not cleared.
  - Reset mid-word discards the half-sent word; the next byte after reset is the high byte of the next word written.

## Timing
- Outputs after reset edge: valid_out=0, data_out=8'h00, empty=1, full=0, level=0, overflow=0.
- Latency, empty buffer: word sampled at edge N → valid_out=1 with its high byte in the cycle after edge N. With ready_in held 1, the low byte follows one cycle later.
- Throughput: 1 byte/cycle with ready_in=1. The upstream packer issues at most 1 word per 2 cycles, so sustained input never overflows while ready_in=1.
- ready_in=0: state holds; no byte is lost or repeated.
- Write into an empty buffer and ready_in in the same cycle: no transfer that cycle (valid_out is still 0).
- level reflects the edge just taken. full asserts the cycle after the DEPTH-th write; overflow asserts the cycle after the dropped word.

## Test plan
- Single word: reset, valid_in=1 with 16'hA55A for one cycle, ready_in=1 → bytes 8'hA5 then 8'h5A on consecutive cycles; then empty=1, level=0.
- Stall: write 16'h1234, ready_in=0 for 5 cycles, then 1 → valid_out=1 and data_out=8'h12 held stable for all 5 stall cycles; then 12, 34 delivered; no duplicate byte.
- Fill/overflow (DEPTH=4): ready_in=0, write 16'h0001, 0002, 0003, 0004, 0005 → full=1 and level=4 after the 4th write; 5th word dropped, overflow=1. Drain with ready_in=1 → bytes 00,01,00,02,00,03,00,04; overflow still 1.
- Wrap and simultaneous: ready_in=1, 10 words 16'h0100+i written every 2 cycles → 20 bytes in order; level never exceeds 1; pointers wrap with no corruption.
- Full + pop same cycle: fill to 4, hold ready_in=1 with ph=1, write 16'hBEEF on the popping cycle → BEEF dropped, overflow=1, level=3.
- Mid-word reset: write 16'hCAFE, accept 8'hCA, assert rst_n=0 for one edge, then write 16'h0F0F → next bytes are 0F, 0F; CA/FE low byte never appears; overflow=0.
